mem_access_stage: RTL and testbench
===================================

Name: mem_access_stage

Overview:
- Memory-access pipeline stage plus MEM/WB pipeline register of the LEGv8 core; sits directly upstream of the write-back mux.
- Takes the EX/MEM bundle and runs loads/stores over a req/ack data-memory bus with variable latency.
- Stalls upstream while an access is outstanding.
- Registers rd_data, ALU_result, MemtoReg, RegWrite and rd for write-back.

Parameters:
DATA_W, 64, data path width (ALU result, store data, load data)
ADDR_W, 64, data-memory address width
REG_W, 5, destination register index width

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  EX/MEM holds a valid instruction
in_alu_result  input  DATA_W  ALU result / effective address
in_store_data  input  DATA_W  store data (Rt)
in_rd  input  REG_W  destination register
in_MemRead  input  1  load
in_MemWrite  input  1  store
in_MemtoReg  input  1  WB select
in_RegWrite  input  1  register write enable
stall  output  1  hold EX/MEM and earlier stages
dmem_req  output  1  memory request
dmem_we  output  1  1 = write, 0 = read
dmem_addr  output  ADDR_W  memory address
dmem_wdata  output  DATA_W  write data
dmem_ack  input  1  request completed this cycle
dmem_rdata  input  DATA_W  read data, valid with dmem_ack
wb_valid  output  1  MEM/WB holds a completed instruction
rd_data  output  DATA_W  load data to WB
ALU_result  output  DATA_W  ALU result to WB
MemtoReg  output  1  to WB
RegWrite  output  1  to register file, forced 0 when wb_valid=0
wb_rd  output  REG_W  write-back destination
misalign_fault  output  1  misaligned access pulse (optional feature)

Behaviour:
- Reset (async, rst_n=0):
  - State -> IDLE.
  - All outputs and internal registers 0, including dmem_req, wb_valid, rd_data, ALU_result, RegWrite.
  - Reset during WAIT abandons the in-flight access; dmem_req drops immediately.
- FSM states: IDLE, WAIT.
- stall is combinational: stall = (IDLE & in_valid & (in_MemRead | in_MemWrite)) | (WAIT & ~dmem_ack).
- IDLE, in_valid, non-memory op:
  - Next edge: MEM/WB loads ALU_result, MemtoReg, RegWrite, wb_rd.
  - wb_valid=1; rd_data holds its value; no stall.
- IDLE, in_valid, memory op:
  - Next edge: latch op internally (addr=in_alu_result, we=in_MemWrite, wdata, rd, control).
  - State -> WAIT; dmem_req=1 registered.
  - wb_valid=0 that edge.
- WAIT:
  - dmem_req, dmem_we, dmem_addr, dmem_wdata held stable until dmem_ack sampled high.
  - On an ack edge: state -> IDLE, dmem_req -> 0, MEM/WB loads the latched op, wb_valid=1.
  - Loads capture dmem_rdata into rd_data; stores leave rd_data unchanged.
- Ack timing: stall is low in the ack cycle, so upstream advances on that same edge. Minimum memory-op latency is 2 cycles from presentation to MEM/WB update.
- IDLE, in_valid=0: next edge wb_valid=0, RegWrite=0, other MEM/WB fields hold.
- dmem_ack while IDLE: ignored.
- in_MemRead and in_MemWrite both 1: treated as a store.
- No flush input; an accepted instruction always completes.
- No arithmetic; widths pass unchanged.

Optional Feature:
- Macro: MEM_ALIGN_CHECK_EN.
- Defined:
  - A memory op with in_alu_result[2:0] != 0 in IDLE issues no request and raises no stall.
  - Next edge: passes to MEM/WB with wb_valid=1, RegWrite forced 0, misalign_fault=1 for exactly one cycle.
- Undefined:
  - misalign_fault tied 0.
  - Addresses are issued unaltered regardless of alignment.

Test Plan:
- Reset: rst_n=0 mid-WAIT with dmem_req=1 -> dmem_req, wb_valid, RegWrite, stall all 0 immediately; state IDLE after release.
- ALU op: in_valid=1, alu_result=0x2A, rd=3, RegWrite=1, MemRead=0 -> next cycle wb_valid=1, ALU_result=0x2A, wb_rd=3, RegWrite=1, stall never high.
- Load with 3-cycle ack delay: addr=0x100, rd=5, MemtoReg=1; dmem_ack=1 with rdata=0xDEADBEEF on 3rd WAIT cycle -> dmem_req held with addr 0x100, we=0; stall high through 2 WAIT cycles, low on ack; next edge rd_data=0xDEADBEEF, wb_rd=5, wb_valid=1.
- Store with immediate ack: addr=0x208, store_data=0x55 -> dmem_we=1, wdata=0x55 one cycle; then wb_valid=1, RegWrite=0, rd_data unchanged.
- Back-to-back load then ALU op, ack in first WAIT cycle -> ALU op accepted on cycle after ack; two consecutive wb_valid=1 cycles, correct data each.
- MEM_ALIGN_CHECK_EN defined: load addr=0x103 -> no dmem_req, misalign_fault=1 one cycle, RegWrite=0; undefined: request issued with addr 0x103.

Source files
------------

// File: rtl/mem_access_stage.sv
// LEGv8 memory-access stage plus MEM/WB register: ALU ops retire in 1 cycle, loads/stores wait on a req/ack bus.
// Optional build macro MEM_ALIGN_CHECK_EN: misaligned memory ops skip the bus and retire with RegWrite=0 plus a fault pulse.
module mem_access_stage #(
   parameter int DATA_W = 64,
   parameter int ADDR_W = 64,
   parameter int REG_W  = 5
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_alu_result,
   input  logic [DATA_W-1:0] in_store_data,
   input  logic [REG_W-1:0]  in_rd,
   input  logic              in_MemRead,
   input  logic              in_MemWrite,
   input  logic              in_MemtoReg,
   input  logic              in_RegWrite,
   output logic              stall,
   output logic              dmem_req,
   output logic              dmem_we,
   output logic [ADDR_W-1:0] dmem_addr,
   output logic [DATA_W-1:0] dmem_wdata,
   input  logic              dmem_ack,
   input  logic [DATA_W-1:0] dmem_rdata,
   output logic              wb_valid,
   output logic [DATA_W-1:0] rd_data,
   output logic [DATA_W-1:0] ALU_result,
   output logic              MemtoReg,
   output logic              RegWrite,
   output logic [REG_W-1:0]  wb_rd,
   output logic              misalign_fault
);

   typedef enum logic {S_IDLE, S_WAIT} state_t;

   state_t             state;
   logic [DATA_W-1:0]  op_alu;
   logic [REG_W-1:0]   op_rd;
   logic               op_memtoreg;
   logic               op_regwrite;
   logic               mem_op;
   logic               misalign;
   logic               issue;

   assign mem_op = in_MemRead | in_MemWrite;

`ifdef MEM_ALIGN_CHECK_EN
   assign misalign = mem_op & (in_alu_result[2:0] != 3'd0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         misalign_fault <= 1'b0;
      else
         misalign_fault <= (state == S_IDLE) & in_valid & misalign;
   end
`else
   assign misalign       = 1'b0;
   assign misalign_fault = 1'b0;
`endif

   assign issue = in_valid & mem_op & ~misalign;
   assign stall = ((state == S_IDLE) & issue) | ((state == S_WAIT) & ~dmem_ack);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= S_IDLE;
         dmem_req    <= 1'b0;
         dmem_we     <= 1'b0;
         dmem_addr   <= '0;
         dmem_wdata  <= '0;
         op_alu      <= '0;
         op_rd       <= '0;
         op_memtoreg <= 1'b0;
         op_regwrite <= 1'b0;
         wb_valid    <= 1'b0;
         rd_data     <= '0;
         ALU_result  <= '0;
         MemtoReg    <= 1'b0;
         RegWrite    <= 1'b0;
         wb_rd       <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (issue) begin
                  // A store wins when both MemRead and MemWrite are set.
                  state       <= S_WAIT;
                  dmem_req    <= 1'b1;
                  dmem_we     <= in_MemWrite;
                  dmem_addr   <= ADDR_W'(in_alu_result);
                  dmem_wdata  <= in_store_data;
                  op_alu      <= in_alu_result;
                  op_rd       <= in_rd;
                  op_memtoreg <= in_MemtoReg;
                  op_regwrite <= in_RegWrite;
                  wb_valid    <= 1'b0;
                  RegWrite    <= 1'b0;
               end else if (in_valid) begin
                  wb_valid   <= 1'b1;
                  ALU_result <= in_alu_result;
                  MemtoReg   <= in_MemtoReg;
                  RegWrite   <= in_RegWrite & ~misalign;
                  wb_rd      <= in_rd;
               end else begin
                  wb_valid <= 1'b0;
                  RegWrite <= 1'b0;
               end
            end
            S_WAIT: begin
               if (dmem_ack) begin
                  state      <= S_IDLE;
                  dmem_req   <= 1'b0;
                  wb_valid   <= 1'b1;
                  ALU_result <= op_alu;
                  MemtoReg   <= op_memtoreg;
                  RegWrite   <= op_regwrite;
                  wb_rd      <= op_rd;
                  if (!dmem_we)
                     rd_data <= dmem_rdata;
               end else begin
                  wb_valid <= 1'b0;
                  RegWrite <= 1'b0;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_access_stage.sv
// Scoreboard bench for mem_access_stage: expected MEM/WB contents are queued at presentation and compared at retirement.
module tb_mem_access_stage;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic [63:0] in_alu_result = '0;
   logic [63:0] in_store_data = '0;
   logic [4:0]  in_rd = '0;
   logic        in_MemRead = 1'b0;
   logic        in_MemWrite = 1'b0;
   logic        in_MemtoReg = 1'b0;
   logic        in_RegWrite = 1'b0;
   logic        stall;
   logic        dmem_req;
   logic        dmem_we;
   logic [63:0] dmem_addr;
   logic [63:0] dmem_wdata;
   logic        dmem_ack = 1'b0;
   logic [63:0] dmem_rdata = '0;
   logic        wb_valid;
   logic [63:0] rd_data;
   logic [63:0] ALU_result;
   logic        MemtoReg;
   logic        RegWrite;
   logic [4:0]  wb_rd;
   logic        misalign_fault;

   typedef struct packed {
      logic [63:0] alu;
      logic [63:0] rdd;
      logic [4:0]  rd;
      logic        m2r;
      logic        rw;
   } exp_t;

   exp_t        sb[$];
   exp_t        e;
   exp_t        got;
   logic [63:0] model_rd_data = '0;
   int          vectors = 0;
   int          miscompares = 0;

   assign got = {ALU_result, rd_data, wb_rd, MemtoReg, RegWrite};

   mem_access_stage #(.DATA_W(64), .ADDR_W(64), .REG_W(5)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_alu_result(in_alu_result),
      .in_store_data(in_store_data), .in_rd(in_rd), .in_MemRead(in_MemRead),
      .in_MemWrite(in_MemWrite), .in_MemtoReg(in_MemtoReg), .in_RegWrite(in_RegWrite),
      .stall(stall), .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
      .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
      .wb_valid(wb_valid), .rd_data(rd_data), .ALU_result(ALU_result), .MemtoReg(MemtoReg),
      .RegWrite(RegWrite), .wb_rd(wb_rd), .misalign_fault(misalign_fault)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_op(input logic v, input logic [63:0] alu, input logic [63:0] sd,
                         input logic [4:0] rd, input logic mr, input logic mw,
                         input logic m2r, input logic rw);
      in_valid = v; in_alu_result = alu; in_store_data = sd; in_rd = rd;
      in_MemRead = mr; in_MemWrite = mw; in_MemtoReg = m2r; in_RegWrite = rw;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #12;
      vectors++;
      if ({dmem_req, wb_valid, RegWrite, stall, misalign_fault} !== 5'b0 || rd_data !== 64'd0 || ALU_result !== 64'd0) begin
         miscompares++;
         $display("FAIL reset_state: req/wb_valid/RegWrite/stall/fault=%b rd_data=%h alu=%h, required all 0",
                  {dmem_req, wb_valid, RegWrite, stall, misalign_fault}, rd_data, ALU_result);
      end
      tick();
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_alu();
      set_op(1'b1, 64'h2A, 64'h0, 5'd3, 1'b0, 1'b0, 1'b0, 1'b1);
      sb.push_back('{alu: 64'h2A, rdd: model_rd_data, rd: 5'd3, m2r: 1'b0, rw: 1'b1});
      #1;
      vectors++;
      if (stall !== 1'b0) begin miscompares++; $display("FAIL alu_stall: got %b required 0", stall); end
      tick();
      set_op(1'b0, 64'h0, 64'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      vectors++;
      if (sb.size() == 0) begin miscompares++; $display("FAIL alu_wb: scoreboard empty"); end
      else begin
         e = sb.pop_front();
         if (wb_valid !== 1'b1 || got !== e) begin
            miscompares++;
            $display("FAIL alu_wb: wb_valid=%b got=%h required wb_valid=1 %h", wb_valid, got, e);
         end
      end
      tick();
      vectors++;
      if (wb_valid !== 1'b0 || RegWrite !== 1'b0) begin
         miscompares++;
         $display("FAIL bubble: wb_valid=%b RegWrite=%b required 0 0", wb_valid, RegWrite);
      end
   endtask

   task automatic test_load_delay();
      set_op(1'b1, 64'h100, 64'h0, 5'd5, 1'b1, 1'b0, 1'b1, 1'b1);
      sb.push_back('{alu: 64'h100, rdd: 64'hDEADBEEF, rd: 5'd5, m2r: 1'b1, rw: 1'b1});
      #1;
      vectors++;
      if (stall !== 1'b1) begin miscompares++; $display("FAIL load_present_stall: got %b required 1", stall); end
      tick();
      set_op(1'b0, 64'h0, 64'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      for (int c = 0; c < 2; c++) begin
         #1;
         vectors++;
         if ({dmem_req, dmem_we, stall, wb_valid} !== 4'b1010 || dmem_addr !== 64'h100) begin
            miscompares++;
            $display("FAIL load_wait%0d: req/we/stall/wb_valid=%b addr=%h required 1010 addr=100",
                     c, {dmem_req, dmem_we, stall, wb_valid}, dmem_addr);
         end
         tick();
      end
      dmem_ack = 1'b1;
      dmem_rdata = 64'hDEADBEEF;
      #1;
      vectors++;
      if (stall !== 1'b0 || dmem_req !== 1'b1) begin
         miscompares++;
         $display("FAIL load_ack_cycle: stall=%b req=%b required 0 1", stall, dmem_req);
      end
      tick();
      dmem_ack = 1'b0;
      dmem_rdata = 64'h0;
      model_rd_data = 64'hDEADBEEF;
      vectors++;
      if (sb.size() == 0) begin miscompares++; $display("FAIL load_wb: scoreboard empty"); end
      else begin
         e = sb.pop_front();
         if (wb_valid !== 1'b1 || dmem_req !== 1'b0 || got !== e) begin
            miscompares++;
            $display("FAIL load_wb: wb_valid=%b req=%b got=%h required 1 0 %h", wb_valid, dmem_req, got, e);
         end
      end
      tick();
   endtask

   // Second pattern sets MemRead too; it must still behave as a store.
   task automatic test_store();
      for (int p = 0; p < 2; p++) begin
         set_op(1'b1, (p == 0) ? 64'h208 : 64'h310, (p == 0) ? 64'h55 : 64'hA5A5,
                5'd7, p[0], 1'b1, 1'b0, 1'b0);
         sb.push_back('{alu: in_alu_result, rdd: model_rd_data, rd: 5'd7, m2r: 1'b0, rw: 1'b0});
         tick();
         vectors++;
         if ({dmem_req, dmem_we} !== 2'b11 || dmem_addr !== in_alu_result || dmem_wdata !== in_store_data) begin
            miscompares++;
            $display("FAIL store%0d_bus: req/we=%b addr=%h wdata=%h required 11 %h %h",
                     p, {dmem_req, dmem_we}, dmem_addr, dmem_wdata, in_alu_result, in_store_data);
         end
         set_op(1'b0, 64'h0, 64'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
         dmem_ack = 1'b1;
         dmem_rdata = 64'hBAD0BAD0;
         tick();
         dmem_ack = 1'b0;
         vectors++;
         if (sb.size() == 0) begin miscompares++; $display("FAIL store%0d_wb: scoreboard empty", p); end
         else begin
            e = sb.pop_front();
            if (wb_valid !== 1'b1 || got !== e) begin
               miscompares++;
               $display("FAIL store%0d_wb: wb_valid=%b got=%h required 1 %h", p, wb_valid, got, e);
            end
         end
         tick();
      end
   endtask

   task automatic test_ack_idle();
      dmem_ack = 1'b1;
      dmem_rdata = 64'h1111;
      tick();
      dmem_ack = 1'b0;
      vectors++;
      if (wb_valid !== 1'b0 || dmem_req !== 1'b0 || rd_data !== model_rd_data) begin
         miscompares++;
         $display("FAIL ack_idle: wb_valid=%b req=%b rd_data=%h required 0 0 %h",
                  wb_valid, dmem_req, rd_data, model_rd_data);
      end
   endtask

   task automatic test_back_to_back();
      int seen;
      seen = 0;
      set_op(1'b1, 64'h40, 64'h0, 5'd9, 1'b1, 1'b0, 1'b1, 1'b1);
      sb.push_back('{alu: 64'h40, rdd: 64'h1234, rd: 5'd9, m2r: 1'b1, rw: 1'b1});
      sb.push_back('{alu: 64'h77, rdd: 64'h1234, rd: 5'd10, m2r: 1'b0, rw: 1'b1});
      tick();
      dmem_ack = 1'b1;
      dmem_rdata = 64'h1234;
      tick();
      dmem_ack = 1'b0;
      model_rd_data = 64'h1234;
      set_op(1'b1, 64'h77, 64'h0, 5'd10, 1'b0, 1'b0, 1'b0, 1'b1);
      for (int c = 0; c < 2; c++) begin
         vectors++;
         if (sb.size() == 0) begin miscompares++; $display("FAIL b2b_%0d: scoreboard empty", c); end
         else begin
            e = sb.pop_front();
            if (wb_valid !== 1'b1 || got !== e) begin
               miscompares++;
               $display("FAIL b2b_%0d: wb_valid=%b got=%h required 1 %h", c, wb_valid, got, e);
            end else seen++;
         end
         tick();
         set_op(1'b0, 64'h0, 64'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      end
      vectors++;
      if (seen != 2) begin miscompares++; $display("FAIL b2b_count: got %0d consecutive retirements required 2", seen); end
   endtask

   task automatic test_misalign();
      int budget;
      set_op(1'b1, 64'h103, 64'h0, 5'd4, 1'b1, 1'b0, 1'b1, 1'b1);
`ifdef MEM_ALIGN_CHECK_EN
      sb.push_back('{alu: 64'h103, rdd: model_rd_data, rd: 5'd4, m2r: 1'b1, rw: 1'b0});
      #1;
      vectors++;
      if (stall !== 1'b0) begin miscompares++; $display("FAIL misalign_stall: got %b required 0", stall); end
      tick();
      set_op(1'b0, 64'h0, 64'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      vectors++;
      if (sb.size() == 0) begin miscompares++; $display("FAIL misalign_wb: scoreboard empty"); end
      else begin
         e = sb.pop_front();
         if ({wb_valid, dmem_req, misalign_fault} !== 3'b101 || got !== e) begin
            miscompares++;
            $display("FAIL misalign_wb: valid/req/fault=%b got=%h required 101 %h",
                     {wb_valid, dmem_req, misalign_fault}, got, e);
         end
      end
      tick();
      vectors++;
      if (misalign_fault !== 1'b0) begin miscompares++; $display("FAIL misalign_pulse: got %b required 0", misalign_fault); end
`else
      sb.push_back('{alu: 64'h103, rdd: 64'hCAFE, rd: 5'd4, m2r: 1'b1, rw: 1'b1});
      tick();
      set_op(1'b0, 64'h0, 64'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      vectors++;
      if (dmem_req !== 1'b1 || dmem_addr !== 64'h103 || misalign_fault !== 1'b0) begin
         miscompares++;
         $display("FAIL unaligned_issue: req=%b addr=%h fault=%b required 1 103 0", dmem_req, dmem_addr, misalign_fault);
      end
      dmem_ack = 1'b1;
      dmem_rdata = 64'hCAFE;
      budget = 0;
      tick();
      dmem_ack = 1'b0;
      while (wb_valid !== 1'b1 && budget < 10) begin tick(); budget++; end
      model_rd_data = 64'hCAFE;
      vectors++;
      if (sb.size() == 0 || wb_valid !== 1'b1) begin
         miscompares++;
         $display("FAIL unaligned_wb: wb_valid=%b never seen within budget, required 1", wb_valid);
         sb.delete();
      end else begin
         e = sb.pop_front();
         if (got !== e) begin miscompares++; $display("FAIL unaligned_wb: got %h required %h", got, e); end
      end
      tick();
`endif
   endtask

   task automatic test_reset_mid_wait();
      set_op(1'b1, 64'h500, 64'h0, 5'd2, 1'b1, 1'b0, 1'b1, 1'b1);
      tick();
      vectors++;
      if (dmem_req !== 1'b1) begin miscompares++; $display("FAIL rst_pre_req: got %b required 1", dmem_req); end
      #2;
      rst_n = 1'b0;
      set_op(1'b0, 64'h0, 64'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      #1;
      vectors++;
      if ({dmem_req, wb_valid, RegWrite, stall} !== 4'b0 || rd_data !== 64'd0) begin
         miscompares++;
         $display("FAIL rst_mid_wait: req/wb_valid/RegWrite/stall=%b rd_data=%h required 0000 0",
                  {dmem_req, wb_valid, RegWrite, stall}, rd_data);
      end
      tick();
      rst_n = 1'b1;
      model_rd_data = 64'h0;
      set_op(1'b1, 64'h99, 64'h0, 5'd6, 1'b0, 1'b0, 1'b0, 1'b1);
      sb.push_back('{alu: 64'h99, rdd: 64'h0, rd: 5'd6, m2r: 1'b0, rw: 1'b1});
      tick();
      set_op(1'b0, 64'h0, 64'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      vectors++;
      if (sb.size() == 0) begin miscompares++; $display("FAIL rst_idle_after: scoreboard empty"); end
      else begin
         e = sb.pop_front();
         if (wb_valid !== 1'b1 || dmem_req !== 1'b0 || got !== e) begin
            miscompares++;
            $display("FAIL rst_idle_after: wb_valid=%b req=%b got=%h required 1 0 %h", wb_valid, dmem_req, got, e);
         end
      end
   endtask

   initial begin
      test_reset();
      test_alu();
      test_load_delay();
      test_store();
      test_ack_idle();
      test_back_to_back();
      test_misalign();
      test_reset_mid_wait();
      tick();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
